alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the 16-bit combinational ALU (74181 arithmetic/logic, 1-bit shift, carry-in select, zero detect).
- Generalised to WIDTH bits. Adds multi-bit shifts (one bit per cycle), arithmetic shift right and shift-add multiply.
- Operands are captured on a start/busy/done handshake; result and flags are registered.
- Sits between the register file read ports and the result bus in the CPU datapath; the control unit drives start and waits for done.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit (master) and the sequential ALU (slave).
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             csel;
    logic             ucin;
    logic             srcin;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             zout;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, csel, ucin, srcin,
        input  y, cout, zout, busy, done
    );

    modport slave (
        input  start, op, a, b, csel, ucin, srcin,
        output y, cout, zout, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: one-cycle logic/arithmetic ops, one-bit-per-cycle shifts, shift-add multiply.
// Operands are captured on start; y/cout/zout update only on the completion edge.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_SBC = 4'd3,
                           OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_NOT = 4'd7,
                           OP_SHL = 4'd8, OP_SHR = 4'd9, OP_SAR = 4'd10, OP_MUL = 4'd11,
                           OP_PASS = 4'd15;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             cin_q, cin_d;
    logic [CW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             cout_q, cout_d;
    logic             zout_q, zout_d;
    logic             done_q, done_d;

    logic [CW-1:0]    shamt;
    logic             is_shift;
    logic [WIDTH-1:0] addend;
    logic             ci;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_val;
    logic             step_out;
    logic             last;

    assign shamt    = bus.b[CW-1:0];
    assign is_shift = (bus.op == OP_SHL) || (bus.op == OP_SHR) || (bus.op == OP_SAR);
    assign last     = (cnt_q == (CW+1)'(1));

    // Single adder shared by ADD/ADC/SUB/SBC; subtraction is a + ~b + carry.
    always_comb begin
        addend = b_q;
        ci     = 1'b0;
        case (op_q)
            OP_ADC:  ci = cin_q;
            OP_SUB:  begin addend = ~b_q; ci = 1'b1;  end
            OP_SBC:  begin addend = ~b_q; ci = cin_q; end
            default: ;
        endcase
        sum     = {1'b0, a_q} + {1'b0, addend} + {{WIDTH{1'b0}}, ci};
        mul_sum = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : '0);
    end

    // One shift step of the working register.
    always_comb begin
        step_val = {a_q[WIDTH-2:0], 1'b0};
        step_out = a_q[WIDTH-1];
        if (op_q == OP_SHR) begin
            step_val = {1'b0, a_q[WIDTH-1:1]};
            step_out = a_q[0];
        end else if (op_q == OP_SAR) begin
            step_val = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            step_out = a_q[0];
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        cin_d   = cin_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        cout_d  = cout_q;
        zout_d  = zout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // A zero-count shift is just a pass-through of a with cout=0.
                    op_d  = (is_shift && shamt == '0) ? OP_PASS : bus.op;
                    a_d   = bus.a;
                    b_d   = bus.b;
                    hi_d  = '0;
                    cin_d = bus.csel ? bus.srcin : bus.ucin;
                    if (is_shift && shamt != '0) cnt_d = {1'b0, shamt};
                    else if (bus.op == OP_MUL)   cnt_d = (CW+1)'(WIDTH);
                    else                         cnt_d = (CW+1)'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q - (CW+1)'(1);
                case (op_q)
                    OP_SHL, OP_SHR, OP_SAR: begin
                        a_d = step_val;
                        if (last) begin
                            y_d    = step_val;
                            cout_d = step_out;
                        end
                    end
                    OP_MUL: begin
                        // {hi, b} is the product/multiplier pair shifted right each step.
                        hi_d = mul_sum[WIDTH:1];
                        b_d  = {mul_sum[0], b_q[WIDTH-1:1]};
                        if (last) begin
                            y_d    = {mul_sum[0], b_q[WIDTH-1:1]};
                            cout_d = |mul_sum[WIDTH:1];
                        end
                    end
                    OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                        y_d    = sum[WIDTH-1:0];
                        cout_d = sum[WIDTH];
                    end
                    OP_AND:  begin y_d = a_q & b_q; cout_d = 1'b0; end
                    OP_OR:   begin y_d = a_q | b_q; cout_d = 1'b0; end
                    OP_XOR:  begin y_d = a_q ^ b_q; cout_d = 1'b0; end
                    OP_NOT:  begin y_d = ~a_q;      cout_d = 1'b0; end
                    default: begin y_d = a_q;       cout_d = 1'b0; end
                endcase
                if (last) begin
                    zout_d  = (y_d == '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            zout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            cin_q   <= cin_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            zout_q  <= zout_d;
            done_q  <= done_d;
        end
    end

    assign bus.y    = y_q;
    assign bus.cout = cout_q;
    assign bus.zout = zout_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: issue() queues expected results, a negedge monitor checks them.
module tb_alu_seq;
    parameter int WIDTH = 16;
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             c;
        logic             z;
        int               at;
        int               id;
    } exp_t;

    exp_t             sbq[$];
    logic [WIDTH-1:0] ly = '0;
    logic             lc = 1'b0;
    logic             lz = 1'b0;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();
    alu_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pop on every done, otherwise results must hold.
    always @(negedge clk) begin
        if (reset) begin
            ly = '0; lc = 1'b0; lz = 1'b0;
        end else if (bus.done) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk($sformatf("y_op%0d", e.id), bus.y, e.y);
                chk($sformatf("cout_op%0d", e.id), WIDTH'(bus.cout), WIDTH'(e.c));
                chk($sformatf("zout_op%0d", e.id), WIDTH'(bus.zout), WIDTH'(e.z));
                chk($sformatf("latency_op%0d", e.id), WIDTH'(cyc), WIDTH'(e.at));
                ly = e.y; lc = e.c; lz = e.z;
            end
        end else begin
            chk("hold_y", bus.y, ly);
            chk("hold_flags", WIDTH'({bus.cout, bus.zout}), WIDTH'({lc, lz}));
        end
    end

    // Waits for busy=0 (scribbling operands meanwhile), presents the op with start high.
    task automatic issue(input int id, input logic [3:0] op, input logic [WIDTH-1:0] a, b,
                         input logic cs, uc, sr, input logic [WIDTH-1:0] ey,
                         input logic ec, ez, input int lat, input bit push = 1'b1);
        int g = 0;
        @(negedge clk);
        while (bus.busy && g < 200) begin
            bus.a  = WIDTH'($urandom);
            bus.b  = WIDTH'($urandom);
            bus.op = 4'($urandom);
            @(negedge clk);
            g++;
        end
        if (bus.busy) begin
            checks++; errors++;
            $display("FAIL busy_timeout_op%0d actual=1 required=0", id);
        end
        bus.op = op; bus.a = a; bus.b = b;
        bus.csel = cs; bus.ucin = uc; bus.srcin = sr;
        bus.start = 1'b1;
        if (push) sbq.push_back('{ey, ec, ez, cyc + 1 + lat, id});
        @(posedge clk);
    endtask

    task automatic drain();
        int g = 0;
        @(negedge clk);
        bus.start = 1'b0;
        while (sbq.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.csel = 1'b0; bus.ucin = 1'b0; bus.srcin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_y", bus.y, '0);
        chk("reset_flags", WIDTH'({bus.cout, bus.zout, bus.busy, bus.done}), '0);
        reset = 1'b0;

        // Nonzero y before the aborted multiply so the reset clear is visible.
        issue(1, 4'd6, 'h00FF, 'h0F0F, 0, 0, 0, 'h0FF0, 0, 0, 1);
        drain();

        // Reset in RUN cycle 4 of MUL 3*5: no done, y cleared.
        issue(2, 4'd11, 3, 5, 0, 0, 0, '0, 0, 0, WIDTH, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midmul_reset_y", bus.y, '0);
        chk("midmul_reset_busy_done", WIDTH'({bus.busy, bus.done}), '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (WIDTH + 4) @(negedge clk);

        issue(3, 4'd0, 1, 1, 0, 0, 0, 2, 0, 0, 1);
        issue(4, 4'd1, ONES, 0, 1, 0, 1, '0, 1, 1, 1);
        issue(5, 4'd1, ONES, 0, 0, 0, 1, ONES, 0, 0, 1);
        issue(6, 4'd2, 3, 5, 0, 0, 0, ONES - 1, 0, 0, 1);
        issue(7, 4'd2, 5, 5, 0, 0, 0, '0, 1, 1, 1);
        issue(8, 4'd3, 5, 3, 0, 0, 0, 1, 1, 0, 1);
        issue(9, 4'd3, 0, 0, 0, 0, 0, ONES, 0, 0, 1);
        issue(10, 4'd0, ONES, 1, 0, 0, 0, '0, 1, 1, 1);
        issue(11, 4'd4, 'h00FF, 'h0F0F, 0, 0, 0, 'h000F, 0, 0, 1);
        issue(12, 4'd5, 'h00FF, 'h0F0F, 0, 0, 0, 'h0FFF, 0, 0, 1);
        issue(13, 4'd7, 'h00FF, 0, 0, 0, 0, ONES ^ 'h00FF, 0, 0, 1);
        issue(14, 4'd13, 'h1234, 'h5678, 0, 0, 0, 'h1234, 0, 0, 1);
        // SAR count 3; bit CW of b set and must be ignored.
        issue(15, 4'd10, MSB | 1, WIDTH + 3, 0, 0, 0, ONES << (WIDTH - 4), 0, 0, 3);
        issue(16, 4'd8, MSB, 0, 0, 0, 0, MSB, 0, 0, 1);
        issue(17, 4'd8, MSB | (MSB >> 1), 1, 0, 0, 0, MSB, 1, 0, 1);
        issue(18, 4'd11, 1 << (WIDTH / 2), 1 << (WIDTH / 2), 0, 0, 0, '0, 1, 1, WIDTH);
        issue(19, 4'd11, 7, 9, 0, 0, 0, 63, 0, 0, WIDTH);
        // Start held high: the ADD must be accepted in the SHR done cycle.
        issue(20, 4'd9, 'h0018, 4, 0, 0, 0, 1, 1, 0, 4);
        issue(21, 4'd0, 2, 3, 0, 0, 0, 5, 0, 0, 1);
        issue(22, 4'd10, MSB, 2, 0, 0, 0, ONES << (WIDTH - 3), 0, 0, 2);
        drain();
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
